cpu_step_ctrl: RTL and testbench

- Run/step/halt controller for the single-cycle processor on the FPGA board.
- Consumes already-debounced, synchronised button levels and produces the processor clock-enable `cpu_en`.
- Supports free-run, single-step with auto-repeat on a held step button, halt, and one PC breakpoint.
- Exposes mode, breakpoint-hit and executed-instruction count for the display logic.

---
 rtl/cpu_step_ctrl.sv | 135 +++++++++++++
 tb/tb_cpu_step_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/step/halt controller for the single-cycle processor: turns debounced button
// levels into the processor clock enable, with step auto-repeat and one PC breakpoint.
`timescale 1ns/1ps
module cpu_step_ctrl #(
  parameter logic [24:0] REPEAT_DELAY = 25'd24999999,
  parameter logic [24:0] REPEAT_RATE  = 25'd4999999,
  parameter int          PC_W         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_btn,
  input  logic            step_btn,
  input  logic            halt_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  output logic            cpu_en,
  output logic [1:0]      mode,
  output logic            bp_hit,
  output logic [15:0]     step_count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        bp_hit_q, bp_hit_d;
  logic        run_prev_q, step_prev_q, halt_prev_q;
  logic        armed_q;
  logic [24:0] rep_cnt_q, rep_cnt_d;
  logic        rep_phase_q, rep_phase_d;
  logic        step_hold_q, step_hold_d;
  logic        step_pulse_q, step_pulse_d;
  logic        skip_bp_q, skip_bp_d;
  logic [15:0] step_count_q, step_count_d;

  logic        halt_rise, run_rise, step_rise;
  logic        bp_match;
  logic        cpu_en_c;
  logic        repeat_due;

  // armed_q masks the first cycle after reset so a button held through reset is not a rise
  always_comb begin
    halt_rise  = halt_btn & ~halt_prev_q & armed_q;
    run_rise   = run_btn  & ~run_prev_q  & armed_q;
    step_rise  = step_btn & ~step_prev_q & armed_q;
    bp_match   = bp_en && (pc == bp_addr) && !skip_bp_q;
    cpu_en_c   = step_pulse_q | ((state_q == S_RUN) && !bp_match);
    repeat_due = (!rep_phase_q && (rep_cnt_q == REPEAT_DELAY)) ||
                 ( rep_phase_q && (rep_cnt_q == REPEAT_RATE));
  end

  always_comb begin
    state_d      = state_q;
    rep_cnt_d    = '0;
    rep_phase_d  = 1'b0;
    step_hold_d  = 1'b0;
    step_pulse_d = 1'b0;
    skip_bp_d    = skip_bp_q;
    step_count_d = step_count_q + {15'd0, cpu_en_c};

    if ((state_q == S_RUN) && cpu_en_c)
      skip_bp_d = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (halt_rise)     state_d = S_HALT;
        else if (bp_match) state_d = S_BREAK;
      end
      default: begin
        if (halt_rise) begin
          state_d = S_HALT;
        end else if (run_rise) begin
          state_d = S_RUN;
          if (state_q == S_BREAK)
            skip_bp_d = 1'b1;
        end else if (step_rise) begin
          step_pulse_d = 1'b1;
          step_hold_d  = 1'b1;
        end else if (step_btn && step_hold_q) begin
          // Only a hold that began with a rise in HALT/BREAK may auto-repeat
          step_hold_d = 1'b1;
          if (repeat_due) begin
            step_pulse_d = 1'b1;
            rep_phase_d  = 1'b1;
          end else begin
            rep_cnt_d   = rep_cnt_q + 25'd1;
            rep_phase_d = rep_phase_q;
          end
        end
      end
    endcase

    bp_hit_d = (state_d == S_BREAK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HALT;
      bp_hit_q     <= 1'b0;
      run_prev_q   <= 1'b0;
      step_prev_q  <= 1'b0;
      halt_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      rep_cnt_q    <= '0;
      rep_phase_q  <= 1'b0;
      step_hold_q  <= 1'b0;
      step_pulse_q <= 1'b0;
      skip_bp_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bp_hit_q     <= bp_hit_d;
      run_prev_q   <= run_btn;
      step_prev_q  <= step_btn;
      halt_prev_q  <= halt_btn;
      armed_q      <= 1'b1;
      rep_cnt_q    <= rep_cnt_d;
      rep_phase_q  <= rep_phase_d;
      step_hold_q  <= step_hold_d;
      step_pulse_q <= step_pulse_d;
      skip_bp_q    <= skip_bp_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_en     = cpu_en_c;
  assign mode       = state_q;
  assign bp_hit     = bp_hit_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random button activity, with a
// scoreboard fed by a behavioural model and drained by a separate monitor.
`timescale 1ns/1ps
module tb_cpu_step_ctrl;

  localparam int D = 10;
  localparam int R = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_btn = 1'b0, step_btn = 1'b0, halt_btn = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = '0, pc = '0;
  logic        cpu_en;
  logic [1:0]  mode;
  logic        bp_hit;
  logic [15:0] step_count;

  cpu_step_ctrl #(.REPEAT_DELAY(25'd10), .REPEAT_RATE(25'd3), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .run_btn(run_btn), .step_btn(step_btn),
    .halt_btn(halt_btn), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .mode(mode), .bp_hit(bp_hit), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    logic [1:0]  mode;
    bit          hit;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Bench-side stimulus state
  bit          g_r, g_s, g_h, g_be, g_pc_auto;
  logic [31:0] g_ba, g_pc, g_pc_mask;

  // Behavioural model: mode as 0 (halt), 2 (run), 3 (break); m_t counts edges since
  // the step rise that started the current hold (-1 when no hold is active).
  int m_mode, m_t, m_cnt;
  bit m_hp, m_rp, m_sp, m_armed, m_pulse, m_skip;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_t = -1; m_cnt = 0;
    m_hp = 0; m_rp = 0; m_sp = 0; m_armed = 0; m_pulse = 0; m_skip = 0;
  endtask

  function automatic bit repeat_pulse(input int t);
    if (t == D + 1) return 1'b1;
    if (t > D + 1 && ((t - (D + 1)) % (R + 1)) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input bit rs);
    bit hr, rr, sr, match, en, np;
    exp_t e;
    reset = rs; run_btn = g_r; step_btn = g_s; halt_btn = g_h;
    bp_en = g_be; bp_addr = g_ba; pc = g_pc;
    hr = g_h && !m_hp && m_armed;
    rr = g_r && !m_rp && m_armed;
    sr = g_s && !m_sp && m_armed;
    match = g_be && (g_pc == g_ba) && !m_skip;
    en = m_pulse || (m_mode == 2 && !match);
    e.en = en; e.mode = 2'(m_mode); e.hit = (m_mode == 3); e.cnt = 16'(m_cnt);
    sb.push_back(e);
    if (rs) begin
      model_reset();
    end else begin
      m_cnt = (m_cnt + int'(en)) % 65536;
      if (m_mode == 2 && en) m_skip = 0;
      np = 0;
      if (hr) begin
        m_mode = 0; m_t = -1;
      end else if (rr) begin
        m_t = -1;
        if (m_mode == 3) m_skip = 1;
        m_mode = 2;
      end else if (m_mode == 2) begin
        m_t = -1;
        if (match) m_mode = 3;
      end else if (sr) begin
        m_t = 0; np = 1;
      end else if (g_s && m_t >= 0) begin
        m_t++; np = repeat_pulse(m_t);
      end else begin
        m_t = -1;
      end
      m_pulse = np;
      m_hp = g_h; m_rp = g_r; m_sp = g_s; m_armed = 1;
    end
    @(posedge clk); #1;
    if (g_pc_auto && en) g_pc = (g_pc + 32'd4) & g_pc_mask;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set; compare against queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cpu_en", int'(cpu_en), int'(e.en));
        chk("mode", int'(mode), int'(e.mode));
        chk("bp_hit", int'(bp_hit), int'(e.hit));
        chk("step_count", int'(step_count), int'(e.cnt));
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    g_r = 0; g_s = 1; g_h = 0; g_be = 0; g_ba = '0; g_pc = '0;
    g_pc_auto = 0; g_pc_mask = 32'h3C;
    step_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Step held through reset: no rise until it falls and rises again
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    run_n(5);
    g_s = 0; run_n(2);
    chk("reset_hold_count", int'(step_count), 0);
    chk("reset_hold_mode", int'(mode), 0);

    // Held step: pulses after N, N+11, N+15, N+19, N+23, N+27
    g_s = 1; run_n(30);
    g_s = 0; run_n(5);
    chk("step_repeat_count", int'(step_count), 6);

    // Free run for 20 instructions
    g_r = 1; run_n(1);
    g_r = 0; run_n(19);
    chk("run_mode", int'(mode), 2);
    g_h = 1; run_n(1);
    g_h = 0; run_n(3);
    chk("run_halt_count", int'(step_count), 26);
    chk("run_halt_mode", int'(mode), 0);

    // Breakpoint at 0x10 on an 8-instruction ring
    g_be = 1; g_ba = 32'h10; g_pc = '0; g_pc_auto = 1; g_pc_mask = 32'h1C;
    g_r = 1; run_n(1);
    g_r = 0; run_n(6);
    chk("bp_first_count", int'(step_count), 30);
    chk("bp_first_mode", int'(mode), 3);
    chk("bp_first_hit", int'(bp_hit), 1);
    g_r = 1; run_n(1);
    g_r = 0; run_n(10);
    chk("bp_second_count", int'(step_count), 38);
    chk("bp_second_mode", int'(mode), 3);
    g_s = 1; run_n(4);
    g_s = 0; run_n(3);
    chk("bp_step_count", int'(step_count), 39);
    chk("bp_step_mode", int'(mode), 3);
    chk("bp_step_pc", int'(g_pc), 32'h14);

    // Priority collisions
    g_be = 0; g_pc_auto = 0; g_pc = '0;
    g_h = 1; run_n(1);
    g_h = 0; run_n(2);
    g_h = 1; g_r = 1; run_n(1);
    g_h = 0; g_r = 0; run_n(2);
    chk("halt_run_same_mode", int'(mode), 0);
    g_r = 1; g_s = 1; run_n(1);
    g_r = 0; g_s = 0; run_n(3);
    chk("run_step_same_count", int'(step_count), 42);
    chk("run_step_same_mode", int'(mode), 2);

    // Reset while running
    cyc(1'b1);
    run_n(3);
    chk("midrun_reset_count", int'(step_count), 0);
    chk("midrun_reset_mode", int'(mode), 0);

    // Random button activity with a breakpoint on a 16-instruction ring
    g_pc_auto = 1; g_pc_mask = 32'h3C;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) g_r = ~g_r;
      if ($urandom_range(0, 4) == 0) g_s = ~g_s;
      if ($urandom_range(0, 19) == 0) g_h = ~g_h;
      if ($urandom_range(0, 49) == 0) g_be = ~g_be;
      if ($urandom_range(0, 29) == 0) g_ba = 32'($urandom_range(0, 15) * 4);
      cyc($urandom_range(0, 299) == 0);
    end

    // Long free run through the 16-bit wrap
    g_r = 0; g_s = 0; g_h = 0; g_be = 0; g_pc_auto = 0;
    run_n(2);
    g_h = 1; run_n(1);
    g_h = 0; run_n(1);
    g_r = 1; run_n(1);
    g_r = 0;
    guard = 0;
    while (m_cnt != 65530 && guard < 70000) begin
      cyc(1'b0);
      guard++;
    end
    chk("wrap_reached", int'(guard < 70000), 1);
    run_n(10);
    chk("wrap_count", int'(step_count), 4);
    g_h = 1; run_n(1);
    g_h = 0; run_n(2);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
